// File: rtl/xs3_onehot_decoder.sv
// xs3_onehot_decoder: two-stage valid/ready pipeline decoding excess-3 to BCD and 9-bit one-hot.
// Optional macro XS3_ERR_CNT_EN builds the saturating invalid-code counter; otherwise err_cnt is 0.
module xs3_onehot_decoder #(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           xs3_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [3:0]           bcd_out,
    output logic [8:0]           onehot_out,
    output logic                 out_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    logic       r_s1_valid;
    logic       r_s1_err;
    logic [3:0] r_s1_bcd;
    logic       r_out_valid;
    logic       r_out_err;
    logic [3:0] r_bcd;
    logic [8:0] r_onehot;
    logic       w_in_fire;
    logic       w_in_err;
    logic       w_s1_adv;
    logic [3:0] w_bcd;
    logic [8:0] w_onehot;

    assign w_in_fire  = in_valid & in_ready;
    assign w_in_err   = (xs3_in < 4'd3) | (xs3_in > 4'd12);
    assign w_s1_adv   = r_s1_valid & (~r_out_valid | out_ready);
    assign in_ready   = ~r_s1_valid | w_s1_adv;
    assign w_bcd      = r_s1_err ? 4'd0 : r_s1_bcd;
    assign w_onehot   = (r_s1_err | (r_s1_bcd == 4'd0)) ? 9'd0 : 9'd1 << (r_s1_bcd - 4'd1);
    assign bcd_out    = r_bcd;
    assign onehot_out = r_onehot;
    assign out_err    = r_out_err;
    assign out_valid  = r_out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
            r_s1_bcd   <= 4'd0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_err   <= w_in_err;
            r_s1_bcd   <= xs3_in - 4'd3;
        end else if (w_s1_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Output registers only change on an s1 advance, so data holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_err   <= 1'b0;
            r_bcd       <= 4'd0;
            r_onehot    <= 9'd0;
        end else if (w_s1_adv) begin
            r_out_valid <= 1'b1;
            r_out_err   <= r_s1_err;
            r_bcd       <= w_bcd;
            r_onehot    <= w_onehot;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

`ifdef XS3_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] r_err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err_cnt <= '0;
        else if (err_clr) r_err_cnt <= '0;
        else if (w_in_fire & w_in_err & ~&r_err_cnt) r_err_cnt <= r_err_cnt + 1'b1;
    end

    assign err_cnt = r_err_cnt;
`else
    logic w_unused_clr;

    assign w_unused_clr = err_clr;
    assign err_cnt      = '0;
`endif
endmodule

// File: tb/tb_xs3_onehot_decoder.sv
// tb_xs3_onehot_decoder: scoreboard bench for xs3_onehot_decoder (main instance plus a 2-bit counter instance).
module tb_xs3_onehot_decoder;
`ifdef XS3_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0] bcd;
        logic [8:0] onehot;
        logic       err;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] xs3_in = 4'd0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] bcd_out;
    logic [8:0] onehot_out;
    logic       out_err;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       err_clr = 1'b0;
    logic [7:0] err_cnt;
    logic       s_in_ready, s_out_err, s_out_valid;
    logic [3:0] s_bcd;
    logic [8:0] s_onehot;
    logic [1:0] s_err_cnt;

    exp_t q[$];
    int   n_chk = 0, n_fail = 0, cyc = 0, m8 = 0, m2 = 0;
    bit   chk_lat = 1'b0;

    xs3_onehot_decoder #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .xs3_in(xs3_in), .in_valid(in_valid), .in_ready(in_ready),
        .bcd_out(bcd_out), .onehot_out(onehot_out), .out_err(out_err), .out_valid(out_valid),
        .out_ready(out_ready), .err_clr(err_clr), .err_cnt(err_cnt)
    );

    xs3_onehot_decoder #(.ERR_CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .xs3_in(xs3_in), .in_valid(in_valid), .in_ready(s_in_ready),
        .bcd_out(s_bcd), .onehot_out(s_onehot), .out_err(s_out_err), .out_valid(s_out_valid),
        .out_ready(out_ready), .err_clr(err_clr), .err_cnt(s_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] c, input int t);
        exp_t e;
        int   d;
        e.err    = (c < 3) || (c > 12);
        d        = e.err ? 0 : int'(c) - 3;
        e.bcd    = 4'(d);
        e.onehot = '0;
        if (d > 0) e.onehot[d-1] = 1'b1;
        e.cyc    = t;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("sb_underflow", 0, 1);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    check("bcd", bcd_out, e.bcd);
                    check("onehot", onehot_out, e.onehot);
                    check("err", out_err, e.err);
                    if (chk_lat) check("latency", cyc - e.cyc, 2);
                end
            end
            if (in_valid && in_ready) begin
                q.push_back(model(xs3_in, cyc));
                if (!err_clr && ((xs3_in < 3) || (xs3_in > 12))) begin
                    if (m8 < 255) m8++;
                    if (m2 < 3) m2++;
                end
            end
            if (err_clr) begin
                m8 = 0;
                m2 = 0;
            end
            cyc++;
        end
    end

    task automatic send(input logic [3:0] c);
        int   n = 0;
        logic f;
        xs3_in   = c;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            f = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!f && n < 50);
        check("send_timeout", f, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", q.size(), 0);
        check("idle_valid", out_valid, 0);
    endtask

    task automatic do_reset;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        err_clr  = 1'b0;
        q.delete();
        m8 = 0;
        m2 = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_bcd", bcd_out, 0);
        check("rst_onehot", onehot_out, 0);
        check("rst_err", out_err, 0);
        check("rst_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_ready", in_ready, 1);
    endtask

    initial begin
        do_reset();
        chk_lat   = 1'b1;
        out_ready = 1'b1;
        send(4'd3);
        send(4'd7);
        send(4'd12);
        drain();
        chk_lat = 1'b0;

        for (int i = 0; i < 16; i++) send(4'(i));
        drain();
        check("sweep_cnt", err_cnt, CNT_EN ? 6 : 0);
        check("sweep_cnt_sat", s_err_cnt, CNT_EN ? 3 : 0);

        do_reset();
        out_ready = 1'b0;
        send(4'd4);
        send(4'd5);
        xs3_in   = 4'd6;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_ready", in_ready, 0);
        check("bp_valid", out_valid, 1);
        check("bp_hold", bcd_out, 1);
        check("bp_hold_oh", onehot_out, 9'b000000001);
        out_ready = 1'b1;
        send(4'd6);
        drain();

        do_reset();
        for (int i = 0; i < 5; i++) send((i % 2 == 0) ? 4'd15 : 4'd1);
        drain();
        check("cnt_five", err_cnt, CNT_EN ? m8 : 0);
        check("cnt_five_abs", err_cnt, CNT_EN ? 5 : 0);
        check("cnt_sat", s_err_cnt, CNT_EN ? 3 : 0);
        err_clr = 1'b1;
        send(4'd14);
        err_clr = 1'b0;
        check("cnt_clr", err_cnt, 0);
        check("cnt_clr_sat", s_err_cnt, 0);
        send(4'd0);
        drain();
        check("cnt_after_clr", err_cnt, CNT_EN ? 1 : 0);
        check("cnt_model", s_err_cnt, CNT_EN ? m2 : 0);

        out_ready = 1'b0;
        send(4'd10);
        send(4'd11);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_valid", out_valid, 0);
        check("async_bcd", bcd_out, 0);
        check("async_onehot", onehot_out, 0);
        check("async_cnt", err_cnt, 0);
        q.delete();
        m8 = 0;
        m2 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", out_valid, 0);
        chk_lat   = 1'b1;
        out_ready = 1'b1;
        send(4'd8);
        drain();
        chk_lat = 1'b0;

        send(4'd15);
        drain();
        check("inv_cnt", err_cnt, CNT_EN ? 1 : 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
